// File: rtl/irq_pkg.sv
// Shared types and constants for the irq_arbiter interrupt controller.
package irq_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAssert,
      StService
   } irq_state_e;

   localparam logic CFG_ENABLE = 1'b0;
   localparam logic CFG_EDGE   = 1'b1;

   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/irq_src_det.sv
// Per-source sampler: edge pulse or level sample into a pending bit, set beats clear.
module irq_src_det (
   input  logic aclk,
   input  logic areset,
   input  logic irq_src,
   input  logic edge_mode,
   input  logic in_service,
   input  logic clr,
   output logic pending
);

   logic sample;
   logic pulse;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         sample  <= 1'b0;
         pulse   <= 1'b0;
         pending <= 1'b0;
      end else begin
         sample <= irq_src;
         pulse  <= irq_src & ~sample;
         if (edge_mode) begin
            // A fresh edge landing on the claim cycle must not be lost.
            if (pulse) begin
               pending <= 1'b1;
            end else if (clr) begin
               pending <= 1'b0;
            end
         end else if (!in_service) begin
            pending <= clr ? 1'b0 : irq_src;
         end
      end
   end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter with claim/complete handshake; define IRQ_RR_EN for round-robin
// arbitration, otherwise the lowest eligible index wins.
module irq_arbiter
   import irq_pkg::*;
#(
   parameter int unsigned NUM_SRC = 8,
   parameter int unsigned ID_W    = id_width(NUM_SRC)
) (
   input  logic               aclk,
   input  logic               areset,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic               cfg_we,
   input  logic               cfg_sel,
   input  logic [NUM_SRC-1:0] cfg_wdata,
   output logic [NUM_SRC-1:0] enable_q,
   output logic [NUM_SRC-1:0] edge_q,
   output logic [NUM_SRC-1:0] pending,
   output logic               ext_irq,
   input  logic               claim_req,
   output logic               claim_valid,
   output logic               claim_empty,
   output logic [ID_W-1:0]    claim_id,
   input  logic               complete_valid,
   input  logic [ID_W-1:0]    complete_id
);

   irq_state_e         state;
   logic [NUM_SRC-1:0] in_service;
   logic [ID_W-1:0]    active_id;
   logic [NUM_SRC-1:0] eligible;
   logic [ID_W-1:0]    winner;
   logic [ID_W-1:0]    search_start;
   logic               grant;
   logic [NUM_SRC-1:0] clr_vec;

   // First requester at or after start, wrapping modulo NUM_SRC.
   function automatic logic [ID_W-1:0] pick(input logic [NUM_SRC-1:0] req,
                                            input logic [ID_W-1:0]    start);
      logic [ID_W-1:0] sel;
      int              idx;
      sel = '0;
      for (int k = int'(NUM_SRC) - 1; k >= 0; k--) begin
         idx = int'(start) + k;
         if (idx >= int'(NUM_SRC)) idx -= int'(NUM_SRC);
         if (req[idx]) sel = ID_W'(idx);
      end
      return sel;
   endfunction

`ifdef IRQ_RR_EN
   logic [ID_W-1:0] rr_ptr;
   assign search_start = rr_ptr;
`else
   assign search_start = '0;
`endif

   assign eligible = pending & enable_q & ~in_service;
   assign winner   = pick(eligible, search_start);
   assign grant    = (state == StAssert) && claim_req && (|eligible);
   assign clr_vec  = grant ? (NUM_SRC'(1) << winner) : '0;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      irq_src_det u_det (
         .aclk      (aclk),
         .areset    (areset),
         .irq_src   (irq_src[i]),
         .edge_mode (edge_q[i]),
         .in_service(in_service[i]),
         .clr       (clr_vec[i]),
         .pending   (pending[i])
      );
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         enable_q <= '0;
         edge_q   <= '0;
      end else if (cfg_we) begin
         unique case (cfg_sel)
            CFG_ENABLE: enable_q <= cfg_wdata;
            CFG_EDGE:   edge_q   <= cfg_wdata;
         endcase
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state       <= StIdle;
         ext_irq     <= 1'b0;
         claim_valid <= 1'b0;
         claim_empty <= 1'b0;
         claim_id    <= '0;
         in_service  <= '0;
         active_id   <= '0;
`ifdef IRQ_RR_EN
         rr_ptr      <= '0;
`endif
      end else begin
         claim_valid <= claim_req;
         // Claims outside a live request, or racing a complete, answer empty.
         if (claim_req) begin
            claim_empty <= ~grant;
            claim_id    <= grant ? winner : '0;
         end
         unique case (state)
            StIdle: begin
               if (|eligible) begin
                  state   <= StAssert;
                  ext_irq <= 1'b1;
               end
            end
            StAssert: begin
               if (grant) begin
                  state      <= StService;
                  ext_irq    <= 1'b0;
                  in_service <= clr_vec;
                  active_id  <= winner;
`ifdef IRQ_RR_EN
                  rr_ptr     <= (winner == ID_W'(NUM_SRC - 1)) ? '0 : winner + 1'b1;
`endif
               end else if (!(|eligible)) begin
                  state   <= StIdle;
                  ext_irq <= 1'b0;
               end
            end
            StService: begin
               if (complete_valid && (complete_id == active_id)) begin
                  in_service <= '0;
                  state      <= StIdle;
               end
            end
            default: begin
               state   <= StIdle;
               ext_irq <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
Interrupt controller in the CSR area. It collects NUM_SRC external interrupt lines and edge-detects or level-samples each one into a pending bit. It arbitrates among pending, enabled sources and drives a single registered ext_irq into the CSR/trap logic. The CPU takes an interrupt through a claim/complete handshake, so only one source is in service at a time.

Parameters:
NUM_SRC, 8, number of interrupt sources (2..32)
ID_W, $clog2(NUM_SRC), width of source index

Ports:
aclk  in  1  clock
areset  in  1  asynchronous reset, active-high
irq_src  in  NUM_SRC  raw interrupt lines (synchronous to aclk)
cfg_we  in  1  config write strobe
cfg_sel  in  1  0 = enable mask, 1 = edge-mode mask
cfg_wdata  in  NUM_SRC  config write data
enable_q  out  NUM_SRC  current enable mask
edge_q  out  NUM_SRC  current mode mask (1 = edge, 0 = level)
pending  out  NUM_SRC  pending bits
ext_irq  out  1  interrupt request to CSR, registered
claim_req  in  1  single-cycle claim strobe from CPU
claim_valid  out  1  claim response, 1-cycle pulse
claim_empty  out  1  qualifies claim_valid: no source granted
claim_id  out  ID_W  granted source index
complete_valid  in  1  end-of-service strobe
complete_id  in  ID_W  index being completed

Behaviour:
- Reset (async): enable_q=0, edge_q=0, pending=0, in_service=0, sample regs=0, ext_irq=0, claim_valid=0, claim_empty=0, claim_id=0, rr_ptr=0, state=IDLE.
- Config: on cfg_we, the selected mask is written at the next edge. A write and a claim in the same cycle: the claim sees the old mask.
- Edge mode, source i:
  - sample_i <= irq_src[i]; pulse_i <= irq_src[i] & ~sample_i.
  - pending[i] is set one edge after pulse_i.
- Level mode: pending[i] <= irq_src[i] every cycle, unless in_service[i]; then it is held.
- Latency, edge mode: irq_src rises before edge k -> pulse after k -> pending after k+1 -> ext_irq after k+2.
- eligible = pending & enable_q & ~in_service.
- FSM states: IDLE, ASSERT, SERVICE.
  - IDLE: if |eligible, go to ASSERT and set ext_irq<=1.
  - ASSERT: ext_irq=1.
    - If eligible drops to 0 (disabled or level released) without claim_req: go to IDLE, ext_irq<=0.
    - On claim_req: winner = lowest eligible index. Next cycle: claim_valid=1, claim_empty=0, claim_id=winner; pending[winner] cleared; in_service[winner] set; ext_irq<=0; go to SERVICE.
  - SERVICE: ext_irq=0; active_id held.
    - complete_valid with complete_id==active_id: clear in_service, go to IDLE.
    - Mismatched complete_id: ignored.
- claim_req in IDLE or SERVICE: next cycle claim_valid=1, claim_empty=1, claim_id=0; no state change.
- Same-cycle edge pulse and claim-clear on one source: set wins, so no event is lost.
- complete_valid and claim_req in the same SERVICE cycle: complete is taken and the claim answers empty.
- complete_valid outside SERVICE: ignored.
- Reset mid-service: everything returns to reset values immediately and any outstanding claim is abandoned.

Optional Feature:
IRQ_RR_EN
- Defined: round-robin arbitration. The search starts at rr_ptr and wraps modulo NUM_SRC. On each grant, rr_ptr <= winner+1, wrapping NUM_SRC-1 -> 0.
- Undefined: fixed priority, lowest index wins; no rr_ptr register.

Decomposition:
- Package irq_pkg holds:
  - FSM state typedef (IDLE/ASSERT/SERVICE);
  - cfg_sel encodings CFG_ENABLE=0, CFG_EDGE=1;
  - ID width helper.
- Sub-module irq_src_det: per-source sample/pulse/pending logic with set-over-clear priority, instantiated NUM_SRC times via generate.
- Priority/round-robin selection is a function in the top module.

Test Plan:
- Edge mode: enable=0x01, edge=0x01, raise irq_src[0] at cycle 10 -> pending[0] at 12, ext_irq at 13; claim -> claim_id=0, claim_empty=0; complete id 0 -> back to IDLE.
- Sources 2 and 5 pending, both enabled; claim -> id 2 (fixed priority) or rr_ptr order with IRQ_RR_EN. Complete 2, claim again -> id 5.
- Level mode on source 3: hold high through service; complete -> ext_irq reasserts 2 cycles later. Drop irq_src[3] before claim -> ext_irq deasserts, state IDLE.
- Claim in IDLE -> claim_valid=1, claim_empty=1. Complete with wrong id in SERVICE -> state unchanged.
- Edge on source 1 in the same cycle its claim clears pending -> pending[1] stays 1.
- Disable source 4 while in ASSERT -> IDLE. Assert areset mid-SERVICE -> all outputs zero asynchronously.
